// File: rtl/sensor_scheduler.sv
// Sensor scheduler: arbitrates host requests and continuous-mode polls onto up
// to four DHT11 interface instances, one transaction at a time. Each
// transaction enables one interface, waits for its done pulse (or a timeout),
// presents a single response, and then idles for two cycles.
//
// Valid/ready: a transfer happens on a rising edge where both valid and ready
// are high; the side raising valid holds its payload stable until that edge.
module sensor_scheduler #(
  parameter int N_SENS         = 4,
  parameter int POLL_CYCLES    = 2_000_000,
  parameter int TIMEOUT_CYCLES = 4_000_000
) (
  input  logic                  i_Clock,
  input  logic                  i_Rst,
  input  logic                  i_req_valid,
  input  logic [1:0]            i_req_addr,
  input  logic [7:0]            i_req_cmd,
  output logic                  o_req_ready,
  output logic [N_SENS-1:0]     o_en,
  output logic [7:0]            o_request,
  input  logic [N_SENS-1:0]     i_done,
  input  logic [8*N_SENS-1:0]   i_data,
  input  logic [6*N_SENS-1:0]   i_cmds,
  output logic                  o_rsp_valid,
  output logic [1:0]            o_rsp_addr,
  output logic [5:0]            o_rsp_cmd,
  output logic [7:0]            o_rsp_data,
  input  logic                  i_rsp_ready,
  output logic [1:0]            o_cont,
  output logic [1:0]            o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  localparam logic [N_SENS-1:0] EN_ONE   = N_SENS'(1);
  localparam logic [2:0]        NS_LIMIT = 3'(N_SENS);
  localparam logic [5:0]        ERR_CMD  = 6'b000001;
  localparam logic [7:0]        ERR_DATA = 8'hFF;

  state_t      state;
  logic [31:0] wait_cnt;
  logic        gap_cnt;
  logic [31:0] poll_timer;
  logic        poll_pending;
  logic        poll_hum_next;
  logic [1:0]  cont_addr;

  logic        poll_go;
  logic        host_go;
  logic        cont_set;
  logic [1:0]  launch_addr;
  logic [7:0]  launch_byte;
  logic [7:0]  poll_byte;
  logic [7:0]  host_byte;
  logic        addr_ok;
  logic        done_hit;
  logic [7:0]  sel_data;
  logic [5:0]  sel_cmd;

  assign o_req_ready = (state == S_IDLE) && !poll_pending;
  assign o_dbg_state = state;

  // Launch decision: a pending poll always wins over the host in IDLE.
  always_comb begin
    poll_go   = (state == S_IDLE) && poll_pending;
    host_go   = (state == S_IDLE) && !poll_pending && i_req_valid;
    cont_set  = host_go && ((i_req_cmd == 8'h34) || (i_req_cmd == 8'h35));

    poll_byte = 8'h32;
    if ((o_cont == 2'b10) || ((o_cont == 2'b11) && poll_hum_next)) begin
      poll_byte = 8'h33;
    end

    case (i_req_cmd)
      8'h34:   host_byte = 8'h32;
      8'h35:   host_byte = 8'h33;
      default: host_byte = i_req_cmd;
    endcase

    launch_addr = poll_go ? cont_addr : i_req_addr;
    launch_byte = poll_go ? poll_byte : host_byte;
    addr_ok     = {1'b0, launch_addr} < NS_LIMIT;
  end

  // Pick the enabled interface's done, data and response code; o_en is one-hot.
  always_comb begin
    done_hit = |(i_done & o_en);
    sel_data = '0;
    sel_cmd  = '0;
    for (int k = 0; k < N_SENS; k++) begin
      if (o_en[k]) begin
        sel_data = i_data[8*k +: 8];
        sel_cmd  = i_cmds[6*k +: 6];
      end
    end
  end

  // Poll timer: free-runs while continuous mode is on; one pending poll max.
  always_ff @(posedge i_Clock) begin
    if (i_Rst) begin
      poll_timer   <= '0;
      poll_pending <= 1'b0;
    end else if (cont_set) begin
      poll_timer <= '0;
    end else if (o_cont == 2'b00) begin
      poll_timer   <= '0;
      poll_pending <= 1'b0;
    end else if (poll_timer == 32'(POLL_CYCLES - 1)) begin
      poll_timer   <= '0;
      poll_pending <= 1'b1;
    end else begin
      poll_timer <= poll_timer + 32'd1;
      if (poll_go) begin
        poll_pending <= 1'b0;
      end
    end
  end

  // Transaction FSM with registered enables, request byte and response.
  always_ff @(posedge i_Clock) begin
    if (i_Rst) begin
      state         <= S_IDLE;
      o_en          <= '0;
      o_request     <= '0;
      o_rsp_valid   <= 1'b0;
      o_rsp_addr    <= '0;
      o_rsp_cmd     <= '0;
      o_rsp_data    <= '0;
      o_cont        <= '0;
      cont_addr     <= '0;
      poll_hum_next <= 1'b0;
      wait_cnt      <= '0;
      gap_cnt       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (poll_go || host_go) begin
            o_request  <= launch_byte;
            o_rsp_addr <= launch_addr;
            wait_cnt   <= '0;
            if (host_go) begin
              case (i_req_cmd)
                8'h34: begin
                  o_cont[0]     <= 1'b1;
                  cont_addr     <= i_req_addr;
                  poll_hum_next <= 1'b0;
                end
                8'h35: begin
                  o_cont[1]     <= 1'b1;
                  cont_addr     <= i_req_addr;
                  poll_hum_next <= 1'b0;
                end
                8'h36:   o_cont[0] <= 1'b0;
                8'h37:   o_cont[1] <= 1'b0;
                default: ;
              endcase
            end else if (o_cont == 2'b11) begin
              poll_hum_next <= !poll_hum_next;
            end
            if (addr_ok) begin
              o_en  <= EN_ONE << launch_addr;
              state <= S_WAIT;
            end else begin
              // Nonexistent sensor: answer immediately with the error code.
              o_en        <= '0;
              o_rsp_valid <= 1'b1;
              o_rsp_cmd   <= ERR_CMD;
              o_rsp_data  <= ERR_DATA;
              state       <= S_RESP;
            end
          end
        end
        S_WAIT: begin
          if (done_hit) begin
            o_en        <= '0;
            o_rsp_valid <= 1'b1;
            o_rsp_cmd   <= sel_cmd;
            o_rsp_data  <= sel_data;
            state       <= S_RESP;
          end else if (wait_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
            o_en        <= '0;
            o_rsp_valid <= 1'b1;
            o_rsp_cmd   <= ERR_CMD;
            o_rsp_data  <= ERR_DATA;
            state       <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        S_RESP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            gap_cnt     <= 1'b0;
            state       <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_cnt) begin
            state <= S_IDLE;
          end else begin
            gap_cnt <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sensor_scheduler.sv
// Bench for sensor_scheduler: a 4-sensor instance (short poll and timeout
// periods) runs a vector table plus poll, hold and reset sequences; a
// 2-sensor instance covers the out-of-range address.
module tb_sensor_scheduler;

  localparam int NS   = 4;
  localparam int POLL = 200;
  localparam int TMO  = 100;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 4-sensor instance
  logic        req_valid, req_ready, rsp_valid, rsp_ready;
  logic [1:0]  req_addr, rsp_addr, cont, dbg_state;
  logic [7:0]  req_cmd, request, rsp_data;
  logic [3:0]  en, done;
  logic [31:0] data;
  logic [23:0] cmds;
  logic [5:0]  rsp_cmd;

  // 2-sensor instance
  logic        req_valid2, req_ready2, rsp_valid2, rsp_ready2;
  logic [1:0]  req_addr2, rsp_addr2, cont2, dbg_state2, en2, done2;
  logic [7:0]  req_cmd2, request2, rsp_data2;
  logic [15:0] data2;
  logic [11:0] cmds2;
  logic [5:0]  rsp_cmd2;

  sensor_scheduler #(.N_SENS(NS), .POLL_CYCLES(POLL), .TIMEOUT_CYCLES(TMO)) dut (
    .i_Clock(clk), .i_Rst(rst),
    .i_req_valid(req_valid), .i_req_addr(req_addr), .i_req_cmd(req_cmd),
    .o_req_ready(req_ready), .o_en(en), .o_request(request),
    .i_done(done), .i_data(data), .i_cmds(cmds),
    .o_rsp_valid(rsp_valid), .o_rsp_addr(rsp_addr), .o_rsp_cmd(rsp_cmd),
    .o_rsp_data(rsp_data), .i_rsp_ready(rsp_ready), .o_cont(cont),
    .o_dbg_state(dbg_state)
  );

  sensor_scheduler #(.N_SENS(2), .POLL_CYCLES(POLL), .TIMEOUT_CYCLES(TMO)) dut2 (
    .i_Clock(clk), .i_Rst(rst),
    .i_req_valid(req_valid2), .i_req_addr(req_addr2), .i_req_cmd(req_cmd2),
    .o_req_ready(req_ready2), .o_en(en2), .o_request(request2),
    .i_done(done2), .i_data(data2), .i_cmds(cmds2),
    .o_rsp_valid(rsp_valid2), .o_rsp_addr(rsp_addr2), .o_rsp_cmd(rsp_cmd2),
    .o_rsp_data(rsp_data2), .i_rsp_ready(rsp_ready2), .o_cont(cont2),
    .o_dbg_state(dbg_state2)
  );

  typedef struct {
    logic [1:0] addr;
    logic [7:0] cmd;
    int         delay;      // cycles in WAIT before done; negative = never
    logic [7:0] data;
    logic [5:0] rcmd;
    logic [3:0] exp_en;
    logic [7:0] exp_req;
    logic [5:0] exp_rsp_cmd;
    logic [7:0] exp_rsp_data;
    logic [1:0] exp_cont;
  } vec_t;

  // Scoreboard: expected {addr, cmd, data} of each response in order
  logic [15:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rsp(input string name);
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      check({name, "_noexp"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check(name, {15'd0, rsp_valid, rsp_addr, rsp_cmd, rsp_data}, {15'd0, 1'b1, e});
    end
  endtask

  // Driver: wait (bounded) for ready, present the request for one accepting edge
  task automatic accept(input logic [1:0] a, input logic [7:0] c);
    int t = 0;
    while (req_ready !== 1'b1 && t < 1000) begin
      tick();
      t++;
    end
    check("accept_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_addr  = a;
    req_cmd   = c;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic drive_done(input logic [1:0] a, input logic [7:0] d, input logic [5:0] c);
    data = {4{8'hEE}};
    cmds = {4{6'h2A}};
    data[a*8 +: 8] = d;
    cmds[a*6 +: 6] = c;
    done = 4'b0001 << a;
    tick();
    done = '0;
  endtask

  // Handshake, then two gap cycles with nothing accepted, then ready again
  task automatic finish_rsp(input string name);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({name, "_gap1"}, {26'd0, rsp_valid, req_ready, en}, 32'd0);
    tick();
    check({name, "_gap2"}, {27'd0, req_ready, en}, 32'd0);
    tick();
    check({name, "_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int n_wait;
    int bad;
    string nm;
    nm = $sformatf("v%0d", idx);
    exp_q.push_back({v.addr, v.exp_rsp_cmd, v.exp_rsp_data});
    accept(v.addr, v.cmd);
    check({nm, "_en"}, {28'd0, en}, {28'd0, v.exp_en});
    check({nm, "_req"}, {24'd0, request}, {24'd0, v.exp_req});
    check({nm, "_cont"}, {30'd0, cont}, {30'd0, v.exp_cont});
    n_wait = (v.delay < 0) ? TMO - 1 : v.delay;
    bad = 0;
    for (int i = 0; i < n_wait; i++) begin
      if (n_wait >= 2 && i == n_wait / 2) begin
        // done from a sensor that is not selected, carrying junk
        data = {4{8'hC3}};
        cmds = {4{6'h15}};
        done = 4'b0001 << (v.addr + 2'd1);
      end
      tick();
      done = '0;
      if (en !== v.exp_en || request !== v.exp_req || rsp_valid !== 1'b0) bad++;
    end
    check({nm, "_wait_stable"}, bad, 0);
    if (v.delay >= 0) drive_done(v.addr, v.data, v.rcmd);
    else tick();
    check({nm, "_en_drop"}, {28'd0, en}, 32'd0);
    check_rsp({nm, "_rsp"});
    finish_rsp(nm);
  endtask

  vec_t vecs[7];
  vec_t pv;
  int   acc_cyc;
  int   bad;

  initial begin
    vecs[0] = '{2'd1, 8'h32, 50, 8'h19, 6'b001000, 4'b0010, 8'h32, 6'b001000, 8'h19, 2'b00};
    vecs[1] = '{2'd0, 8'h41,  3, 8'h55, 6'b000100, 4'b0001, 8'h41, 6'b000100, 8'h55, 2'b00};
    vecs[2] = '{2'd3, 8'h36,  0, 8'hA5, 6'b111111, 4'b1000, 8'h36, 6'b111111, 8'hA5, 2'b00};
    vecs[3] = '{2'd2, 8'h37, 10, 8'h3C, 6'b010101, 4'b0100, 8'h37, 6'b010101, 8'h3C, 2'b00};
    vecs[4] = '{2'd2, 8'h33, -1, 8'h00, 6'b000000, 4'b0100, 8'h33, 6'b000001, 8'hFF, 2'b00};
    vecs[5] = '{2'd3, 8'h35,  5, 8'h44, 6'b001001, 4'b1000, 8'h33, 6'b001001, 8'h44, 2'b10};
    vecs[6] = '{2'd1, 8'h37,  2, 8'h11, 6'b000010, 4'b0010, 8'h37, 6'b000010, 8'h11, 2'b00};

    rst = 1'b1;
    req_valid = 0; req_addr = 0; req_cmd = 0; done = 0; data = 0; cmds = 0; rsp_ready = 0;
    req_valid2 = 0; req_addr2 = 0; req_cmd2 = 0; done2 = 0; data2 = 0; cmds2 = 0; rsp_ready2 = 0;
    repeat (3) tick();
    check("rst_en", {28'd0, en}, 32'd0);
    check("rst_outs", {request, rsp_valid, rsp_addr, rsp_cmd, rsp_data, cont, dbg_state}, 32'd0);
    check("rst_outs2", {en2, request2, rsp_valid2, rsp_addr2, rsp_cmd2, rsp_data2, cont2, dbg_state2}, 32'd0);
    rst = 1'b0;
    tick();
    check("rst_ready", {30'd0, req_ready, req_ready2}, 32'd3);

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Continuous temperature on sensor 0; host collides with the poll
    pv = '{2'd0, 8'h34, 5, 8'h16, 6'b001000, 4'b0001, 8'h32, 6'b001000, 8'h16, 2'b01};
    exp_q.push_back({pv.addr, pv.exp_rsp_cmd, pv.exp_rsp_data});
    accept(pv.addr, pv.cmd);
    acc_cyc = cyc;
    check("cont_on", {30'd0, cont}, 32'd1);
    check("cont_en", {28'd0, en}, 32'd1);
    check("cont_req", {24'd0, request}, 32'h32);
    repeat (5) tick();
    drive_done(2'd0, 8'h16, 6'b001000);
    check_rsp("cont_rsp");
    finish_rsp("cont");
    while (cyc < acc_cyc + POLL - 1) tick();
    check("poll_pre_ready", {31'd0, req_ready}, 32'd1);
    tick();
    check("poll_pending_ready", {31'd0, req_ready}, 32'd0);
    req_valid = 1'b1;
    req_addr  = 2'd2;
    req_cmd   = 8'h41;
    exp_q.push_back({2'd0, 6'b001000, 8'h17});
    exp_q.push_back({2'd2, 6'b000011, 8'h2B});
    tick();
    check("poll_en", {28'd0, en}, 32'd1);
    check("poll_req", {24'd0, request}, 32'h32);
    drive_done(2'd0, 8'h17, 6'b001000);
    check_rsp("poll_rsp");
    finish_rsp("poll");
    tick();
    req_valid = 1'b0;
    check("host_after_poll_en", {28'd0, en}, 32'b0100);
    check("host_after_poll_req", {24'd0, request}, 32'h41);
    drive_done(2'd2, 8'h2B, 6'b000011);
    check_rsp("host_after_poll_rsp");
    finish_rsp("host_after_poll");
    run_vec(7, '{2'd0, 8'h36, 2, 8'h21, 6'b000110, 4'b0001, 8'h36, 6'b000110, 8'h21, 2'b00});
    bad = 0;
    repeat (450) begin
      tick();
      if (en !== 4'd0 || req_ready !== 1'b1 || cont !== 2'b00) bad++;
    end
    check("no_more_polls", bad, 0);

    // Response held while the consumer stalls
    exp_q.push_back({2'd1, 6'b000111, 8'h66});
    accept(2'd1, 8'h41);
    drive_done(2'd1, 8'h66, 6'b000111);
    bad = 0;
    repeat (30) begin
      if ({rsp_valid, rsp_addr, rsp_cmd, rsp_data} !== {1'b1, 2'd1, 6'b000111, 8'h66}) bad++;
      tick();
    end
    check("hold_stable", bad, 0);
    check_rsp("hold_rsp");
    finish_rsp("hold");

    // Reset in the middle of WAIT with continuous humidity enabled
    accept(2'd3, 8'h35);
    check("pre_rst_cont", {30'd0, cont}, 32'b10);
    check("pre_rst_en", {28'd0, en}, 32'b1000);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_en", {28'd0, en}, 32'd0);
    check("mid_rst_outs", {request, rsp_valid, rsp_addr, rsp_cmd, rsp_data, cont, dbg_state}, 32'd0);
    check("mid_rst_ready", {31'd0, req_ready}, 32'd1);

    // Out-of-range address on the 2-sensor instance
    check("inv_pre_ready", {31'd0, req_ready2}, 32'd1);
    req_valid2 = 1'b1;
    req_addr2  = 2'd3;
    req_cmd2   = 8'h41;
    tick();
    req_valid2 = 1'b0;
    check("inv_en", {30'd0, en2}, 32'd0);
    check("inv_rsp", {15'd0, rsp_valid2, rsp_addr2, rsp_cmd2, rsp_data2},
          {15'd0, 1'b1, 2'd3, 6'b000001, 8'hFF});
    rsp_ready2 = 1'b1;
    tick();
    rsp_ready2 = 1'b0;
    check("inv_gap1", {30'd0, rsp_valid2, req_ready2}, 32'd0);
    tick();
    tick();
    check("inv_ready", {31'd0, req_ready2}, 32'd1);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sensor_scheduler.md
SENSOR_SCHEDULER -- requirements
Module: sensor_scheduler

Interface
REQ-001 SHALL have parameter N_SENS, default 4, meaning number of attached DHT11 interface instances (1..4).
REQ-002 SHALL have parameter POLL_CYCLES, default 2_000_000, meaning clock cycles between continuous-mode polls.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 4_000_000, meaning maximum cycles to wait for interface done.
REQ-004 SHALL have i_Clock, input, 1, meaning the single system clock.
REQ-005 SHALL have i_Rst, input, 1; reset is synchronous and active-high.
REQ-006 SHALL have i_req_valid, input, 1, meaning decoder request present.
REQ-007 SHALL have i_req_addr, input, 2, meaning target sensor index.
REQ-008 SHALL have i_req_cmd, input, 8, meaning request byte (ASCII code).
REQ-009 SHALL have o_req_ready, output, 1, meaning request accepted when high with i_req_valid.
REQ-010 SHALL have o_en, output, N_SENS, meaning one-hot interface enables.
REQ-011 SHALL have o_request, output, 8, meaning request byte shared by all interfaces.
REQ-012 SHALL have i_done, input, N_SENS, meaning per-interface done pulses.
REQ-013 SHALL have i_data, input, 8*N_SENS, meaning packed interface data, sensor k at [8k+7:8k].
REQ-014 SHALL have i_cmds, input, 6*N_SENS, meaning packed response codes, sensor k at [6k+5:6k].
REQ-015 SHALL have o_rsp_valid, output, 1; o_rsp_addr, output, 2; o_rsp_cmd, output, 6; o_rsp_data, output, 8.
REQ-016 SHALL have i_rsp_ready, input, 1, meaning the response consumer accepts.
REQ-017 SHALL have o_cont, output, 2, meaning continuous mode flags, bit0 temperature, bit1 humidity.

Function
REQ-018 SHALL implement states IDLE, WAIT, RESP, GAP; o_req_ready SHALL be high only in IDLE with no poll pending.
REQ-019 IDLE: accept on i_req_valid&o_req_ready; o_en[addr] and o_request SHALL be driven from the next cycle; go to WAIT.
REQ-020 Poll pending SHALL take priority over a host request in IDLE; poll issues 0x32 (temp) or 0x33 (hum) to the stored continuous address, temperature first if both flags are set, then alternating.
REQ-021 Poll timer SHALL count in every state while any o_cont bit is set, set poll pending at POLL_CYCLES-1, reload, and clear pending when the poll is issued; a second expiry while pending SHALL be lost (no queue).
REQ-022 Request 0x34/0x35 SHALL set o_cont bit0/bit1, store the address, forward 0x32/0x33 to the interface, and reload the timer.
REQ-023 Request 0x36/0x37 SHALL clear o_cont bit0/bit1 on acceptance and be forwarded unchanged; all other bytes SHALL be forwarded unchanged.
REQ-024 o_request and o_en SHALL be held stable throughout WAIT.
REQ-025 WAIT: on i_done[sel] capture i_data/i_cmds slice of sel; o_en SHALL go to all-zero and o_rsp_valid high on the next cycle (RESP).
REQ-026 WAIT timeout: after TIMEOUT_CYCLES without done, SHALL respond cmd 6'b000001, data 8'hFF, with o_en dropped.
REQ-027 i_req_addr >= N_SENS SHALL produce no enable and go directly to RESP with cmd 6'b000001, data 8'hFF, the cycle after acceptance.
REQ-028 RESP: o_rsp_* SHALL be held stable until i_rsp_ready; then GAP for exactly 2 cycles with o_en zero, then IDLE.
REQ-029 i_done on a non-selected bit SHALL be ignored.
REQ-030 Poll responses SHALL use the same RESP path; o_rsp_addr equals the stored continuous address.

Reset
REQ-031 On i_Rst high at a clock edge: state IDLE, o_en 0, o_request 0, o_rsp_valid 0, o_rsp_addr/cmd/data 0, o_cont 0, timers cleared, poll pending 0, regardless of state; o_req_ready SHALL be 1 the first cycle after reset deasserts.

Verification
REQ-032 Request addr 1, cmd 0x32; model sets i_done[1] after 50 cycles with data 0x19, cmds 001000 -> o_en=0010 during wait, o_rsp_valid with addr 1, cmd 001000, data 0x19 the cycle after done.
REQ-033 Request addr 3 with N_SENS=2 -> no o_en, response cmd 000001, data 0xFF next cycle.
REQ-034 No done for TIMEOUT_CYCLES (set to 100) -> o_en drops, response cmd 000001, data 0xFF; next request accepted after handshake+2 cycles.
REQ-035 POLL_CYCLES=200: cmd 0x34 addr 0, then host request on the cycle poll becomes pending -> poll (0x32, addr 0) issued first, host request served next; 0x36 -> o_cont=00, no further polls.
REQ-036 Hold i_rsp_ready low 30 cycles -> o_rsp_* stable; assert i_Rst mid-WAIT -> all outputs zero next cycle.
